// File: rtl/mips_rtype_multicycle.sv
// Multi-cycle R-type execution unit: internal register file, valid/ready issue,
// IDLE -> READ -> EXEC -> WB sequencing, overflow/illegal flags and a debug port.
module mips_rtype_multicycle #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int SH_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [4:0]        wb_addr,
  output logic              ovf,
  output logic              illegal,
  input  logic              dbg_we,
  input  logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [1:0]               state;
  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic                     fire;
  logic                     wb_we;
  logic [DATA_W-1:0]        rs_val;
  logic [DATA_W-1:0]        rt_val;
  logic [31:0]              instr_p0;
  logic signed [DATA_W-1:0] op_a_p1;
  logic signed [DATA_W-1:0] op_b_p1;
  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;
  logic [DATA_W-1:0]        alu_res;
  logic                     alu_ovf;
  logic                     alu_ill;
  logic [DATA_W-1:0]        result_p2;
  logic                     ovf_p2;
  logic                     illegal_p2;

  function automatic logic reg_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [4:0] a);
    return IDX_W'(a);
  endfunction

  function automatic logic add_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // kind follows funct[1:0]: 00 left, 10 logical right, 11 arithmetic right.
  // Amounts past the datapath width saturate to zero / sign fill.
  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] v,
                                                 input logic [5:0] amt, input logic [1:0] kind);
    if (int'(amt) >= DATA_W)
      return (kind == 2'b11) ? {DATA_W{v[DATA_W-1]}} : '0;
    case (kind)
      2'b00:   return v << amt;
      2'b10:   return v >> amt;
      default: return $signed(v) >>> amt;
    endcase
  endfunction

  assign instr_ready = (state == IDLE);
  assign fire        = instr_valid && instr_ready;
  assign dbg_rdata   = reg_ok(dbg_addr) ? regs[reg_idx(dbg_addr)] : '0;
  assign rs_val      = reg_ok(instr_p0[25:21]) ? regs[reg_idx(instr_p0[25:21])] : '0;
  assign rt_val      = reg_ok(instr_p0[20:16]) ? regs[reg_idx(instr_p0[20:16])] : '0;
  assign sum         = op_a_p1 + op_b_p1;
  assign diff        = op_a_p1 - op_b_p1;
  assign wb_we       = !illegal_p2 && !ovf_p2 && reg_ok(instr_p0[15:11]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    if (instr_p0[31:26] != 6'd0) begin
      alu_ill = 1'b1;
    end else begin
      case (instr_p0[5:0])
        6'h20: begin alu_res = sum;  alu_ovf = add_ovf(op_a_p1, op_b_p1, sum);  end
        6'h21: alu_res = sum;
        6'h22: begin alu_res = diff; alu_ovf = sub_ovf(op_a_p1, op_b_p1, diff); end
        6'h23: alu_res = diff;
        6'h24: alu_res = op_a_p1 & op_b_p1;
        6'h25: alu_res = op_a_p1 | op_b_p1;
        6'h26: alu_res = op_a_p1 ^ op_b_p1;
        6'h27: alu_res = ~(op_a_p1 | op_b_p1);
        6'h2a: alu_res = DATA_W'(op_a_p1 < op_b_p1);
        6'h2b: alu_res = DATA_W'($unsigned(op_a_p1) < $unsigned(op_b_p1));
        6'h00, 6'h02, 6'h03:
          alu_res = shift_op(op_b_p1, {1'b0, instr_p0[10:6]}, instr_p0[1:0]);
        6'h04, 6'h06, 6'h07:
          alu_res = shift_op(op_b_p1, 6'(op_a_p1[SH_W-1:0]), instr_p0[1:0]);
        default: alu_ill = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (fire) state <= READ;
        READ:    state <= EXEC;
        EXEC:    state <= WB;
        default: state <= IDLE;
      endcase
    end
  end

  // p0: instruction capture at fire; p1: operand fetch; p2: ALU result
  always_ff @(posedge clk) begin
    if (fire) instr_p0 <= instr;
    if (state == READ) begin
      op_a_p1 <= rs_val;
      op_b_p1 <= rt_val;
    end
    if (state == EXEC) begin
      result_p2  <= alu_res;
      ovf_p2     <= alu_ovf;
      illegal_p2 <= alu_ill;
    end
  end

  // retire: register write and output update land on the WB -> IDLE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      wb_addr      <= 5'd0;
      ovf          <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      result_valid <= (state == WB);
      if (state == WB) begin
        result  <= result_p2;
        wb_addr <= instr_p0[15:11];
        ovf     <= ovf_p2;
        illegal <= illegal_p2;
        if (wb_we) regs[reg_idx(instr_p0[15:11])] <= result_p2;
      end else if (state == IDLE && dbg_we && !fire && reg_ok(dbg_addr)) begin
        regs[reg_idx(dbg_addr)] <= dbg_wdata;
      end
    end
  end
endmodule

// File: tb/tb_mips_rtype_multicycle.sv
// Directed bench for mips_rtype_multicycle: 32-bit default build plus a 16-bit build.
module tb_mips_rtype_multicycle;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] result;
  logic        result_valid;
  logic [4:0]  wb_addr;
  logic        ovf;
  logic        illegal;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;

  logic        h_instr_valid;
  logic [31:0] h_instr;
  logic        h_instr_ready;
  logic [15:0] h_result;
  logic        h_result_valid;
  logic [4:0]  h_wb_addr;
  logic        h_ovf;
  logic        h_illegal;
  logic        h_dbg_we;
  logic [4:0]  h_dbg_addr;
  logic [15:0] h_dbg_wdata;
  logic [15:0] h_dbg_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_rtype_multicycle u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .result(result), .result_valid(result_valid),
    .wb_addr(wb_addr), .ovf(ovf), .illegal(illegal), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  mips_rtype_multicycle #(.DATA_W(16), .NUM_REGS(32)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .instr_valid(h_instr_valid), .instr(h_instr),
    .instr_ready(h_instr_ready), .result(h_result), .result_valid(h_result_valid),
    .wb_addr(h_wb_addr), .ovf(h_ovf), .illegal(h_illegal), .dbg_we(h_dbg_we),
    .dbg_addr(h_dbg_addr), .dbg_wdata(h_dbg_wdata), .dbg_rdata(h_dbg_rdata)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
  endtask

  task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a; #1;
    d = dbg_rdata;
  endtask

  // Issue from IDLE and return the number of edges after fire until result_valid (99 = timeout).
  task automatic run(input logic [31:0] ins, output int lat);
    lat = 99;
    instr_valid = 1'b1; instr = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = i; break; end
    end
  endtask

  task automatic h_write(input logic [4:0] a, input logic [15:0] d);
    h_dbg_we = 1'b1; h_dbg_addr = a; h_dbg_wdata = d;
    @(posedge clk); #1;
    h_dbg_we = 1'b0;
  endtask

  task automatic h_run(input logic [31:0] ins, output int lat);
    lat = 99;
    h_instr_valid = 1'b1; h_instr = ins;
    @(posedge clk); #1;
    h_instr_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (h_result_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    h_instr_valid = 1'b0; h_instr = '0; h_dbg_we = 1'b0; h_dbg_addr = '0; h_dbg_wdata = '0;
    #22;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%0b exp=0", result_valid); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if ({wb_addr, ovf, illegal} !== 7'd0) begin failures++; $display("FAIL reset_flags got=%h exp=0", {wb_addr, ovf, illegal}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", instr_ready); end
    dbg_read(5'd7, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_reg got=%h exp=0", rd); end
  endtask

  task automatic test_add();
    int lat;
    logic [31:0] rd;
    dbg_write(5'd16, 32'd5);
    dbg_write(5'd17, 32'd3);
    run(rtype(5'd16, 5'd17, 5'd18, 5'd0, 6'h20), lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
    checks++; if (result !== 32'd8) begin failures++; $display("FAIL add_result got=%h exp=8", result); end
    checks++; if (wb_addr !== 5'd18) begin failures++; $display("FAIL add_wb_addr got=%0d exp=18", wb_addr); end
    dbg_read(5'd18, rd);
    checks++; if (rd !== 32'd8) begin failures++; $display("FAIL add_r18 got=%h exp=8", rd); end
    @(posedge clk); #1;
    checks++; if (result_valid !== 1'b0 || result !== 32'd8) begin failures++; $display("FAIL add_pulse_hold got=%0b/%h exp=0/8", result_valid, result); end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] rd;
    dbg_write(5'd16, 32'h7FFF_FFFF);
    dbg_write(5'd17, 32'd1);
    dbg_write(5'd18, 32'd0);
    run(rtype(5'd16, 5'd17, 5'd18, 5'd0, 6'h20), lat);
    checks++; if (ovf !== 1'b1 || result !== 32'h8000_0000) begin failures++; $display("FAIL add_ovf got=%0b/%h exp=1/80000000", ovf, result); end
    dbg_read(5'd18, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL ovf_nowrite got=%h exp=0", rd); end
    run(rtype(5'd16, 5'd17, 5'd19, 5'd0, 6'h21), lat);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL addu_ovf got=%0b exp=0", ovf); end
    dbg_read(5'd19, rd);
    checks++; if (rd !== 32'h8000_0000) begin failures++; $display("FAIL addu_r19 got=%h exp=80000000", rd); end
    dbg_write(5'd16, 32'h8000_0000);
    run(rtype(5'd16, 5'd17, 5'd20, 5'd0, 6'h22), lat);
    checks++; if (ovf !== 1'b1 || result !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sub_ovf got=%0b/%h exp=1/7fffffff", ovf, result); end
  endtask

  task automatic test_slt_shift();
    int lat;
    logic [31:0] rd;
    dbg_write(5'd16, 32'hFFFF_FFFF);
    dbg_write(5'd17, 32'd1);
    run(rtype(5'd16, 5'd17, 5'd20, 5'd0, 6'h2a), lat);
    checks++; if (result !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=1", result); end
    dbg_read(5'd20, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL slt_r20 got=%h exp=1", rd); end
    run(rtype(5'd16, 5'd17, 5'd21, 5'd0, 6'h2b), lat);
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL sltu got=%h exp=0", result); end
    dbg_write(5'd17, 32'h8000_0000);
    run(rtype(5'd0, 5'd17, 5'd22, 5'd4, 6'h03), lat);
    checks++; if (result !== 32'hF800_0000) begin failures++; $display("FAIL sra got=%h exp=f8000000", result); end
    run(rtype(5'd0, 5'd17, 5'd22, 5'd4, 6'h02), lat);
    checks++; if (result !== 32'h0800_0000) begin failures++; $display("FAIL srl got=%h exp=08000000", result); end
    dbg_write(5'd16, 32'd33);
    run(rtype(5'd16, 5'd17, 5'd23, 5'd0, 6'h07), lat);
    checks++; if (result !== 32'hC000_0000) begin failures++; $display("FAIL srav got=%h exp=c0000000", result); end
    run(rtype(5'd16, 5'd17, 5'd23, 5'd0, 6'h04), lat);
    checks++; if (result !== 32'h0000_0000) begin failures++; $display("FAIL sllv got=%h exp=0", result); end
    dbg_write(5'd16, 32'hF0F0_F0F0);
    dbg_write(5'd17, 32'hFF00_FF00);
    run(rtype(5'd16, 5'd17, 5'd24, 5'd0, 6'h26), lat);
    checks++; if (result !== 32'h0FF0_0FF0) begin failures++; $display("FAIL xor got=%h exp=0ff00ff0", result); end
    run(rtype(5'd16, 5'd17, 5'd24, 5'd0, 6'h27), lat);
    checks++; if (result !== 32'h000F_000F) begin failures++; $display("FAIL nor got=%h exp=000f000f", result); end
  endtask

  task automatic test_back_to_back();
    int low;
    int lat;
    logic [31:0] rd;
    dbg_write(5'd16, 32'd10);
    dbg_write(5'd17, 32'd4);
    instr_valid = 1'b1;
    instr = rtype(5'd16, 5'd17, 5'd1, 5'd0, 6'h20);
    @(posedge clk); #1;
    instr = rtype(5'd1, 5'd17, 5'd2, 5'd0, 6'h22);
    low = 0;
    while (!instr_ready && low < 10) begin
      low++;
      @(posedge clk); #1;
    end
    checks++; if (low !== 3) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=3", low); end
    checks++; if (result_valid !== 1'b1 || result !== 32'd14) begin failures++; $display("FAIL b2b_first got=%0b/%h exp=1/e", result_valid, result); end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = i; break; end
    end
    checks++; if (lat !== 3 || result !== 32'd10) begin failures++; $display("FAIL b2b_second got=%0d/%h exp=3/a", lat, result); end
    dbg_read(5'd2, rd);
    checks++; if (rd !== 32'd10) begin failures++; $display("FAIL b2b_r2 got=%h exp=a", rd); end
  endtask

  task automatic test_illegal();
    int lat;
    logic [31:0] rd;
    run({6'h23, 5'd16, 5'd17, 5'd5, 5'd0, 6'h20}, lat);
    checks++; if (illegal !== 1'b1 || result !== 32'd0 || ovf !== 1'b0) begin failures++; $display("FAIL ill_opcode got=%0b/%h/%0b exp=1/0/0", illegal, result, ovf); end
    dbg_read(5'd5, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL ill_opcode_r5 got=%h exp=0", rd); end
    run(rtype(5'd16, 5'd17, 5'd6, 5'd0, 6'h3F), lat);
    checks++; if (illegal !== 1'b1 || result !== 32'd0) begin failures++; $display("FAIL ill_funct got=%0b/%h exp=1/0", illegal, result); end
    dbg_read(5'd6, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL ill_funct_r6 got=%h exp=0", rd); end
    run(rtype(5'd16, 5'd17, 5'd0, 5'd0, 6'h20), lat);
    checks++; if (illegal !== 1'b0 || wb_addr !== 5'd0 || result !== 32'd14) begin failures++; $display("FAIL rd0_result got=%0b/%0d/%h exp=0/0/e", illegal, wb_addr, result); end
    dbg_write(5'd0, 32'hDEAD_BEEF);
    dbg_read(5'd0, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL r0_zero got=%h exp=0", rd); end
  endtask

  task automatic test_debug();
    logic [31:0] rd;
    dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'h0000_00AB; #1;
    checks++; if (dbg_rdata !== 32'd0) begin failures++; $display("FAIL dbg_prewrite got=%h exp=0", dbg_rdata); end
    @(posedge clk); #1;
    dbg_we = 1'b0;
    checks++; if (dbg_rdata !== 32'h0000_00AB) begin failures++; $display("FAIL dbg_postwrite got=%h exp=ab", dbg_rdata); end
    instr_valid = 1'b1;
    instr = rtype(5'd16, 5'd17, 5'd25, 5'd0, 6'h21);
    dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h55;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    dbg_we = 1'b0;
    dbg_read(5'd9, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL dbg_blocked got=%h exp=0", rd); end
    dbg_read(5'd25, rd);
    checks++; if (rd !== 32'd14) begin failures++; $display("FAIL dbg_fire_r25 got=%h exp=e", rd); end
  endtask

  task automatic test_async_reset();
    logic seen;
    logic [31:0] rd;
    dbg_write(5'd16, 32'd5);
    dbg_write(5'd17, 32'd3);
    instr_valid = 1'b1;
    instr = rtype(5'd16, 5'd17, 5'd26, 5'd0, 6'h20);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0; #1;
    checks++; if (result !== 32'd0 || wb_addr !== 5'd0) begin failures++; $display("FAIL arst_outputs got=%h/%0d exp=0/0", result, wb_addr); end
    dbg_read(5'd16, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL arst_regs got=%h exp=0", rd); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL arst_no_retire got=%0b exp=0", seen); end
    dbg_read(5'd26, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL arst_r26 got=%h exp=0", rd); end
  endtask

  task automatic test_width16();
    int lat;
    h_write(5'd17, 16'h8001);
    h_write(5'd16, 16'h0013);
    h_run(rtype(5'd0, 5'd17, 5'd3, 5'd20, 6'h00), lat);
    checks++; if (lat !== 3 || h_result !== 16'h0000) begin failures++; $display("FAIL w16_sll20 got=%0d/%h exp=3/0", lat, h_result); end
    h_run(rtype(5'd0, 5'd17, 5'd3, 5'd20, 6'h03), lat);
    checks++; if (h_result !== 16'hFFFF) begin failures++; $display("FAIL w16_sra20 got=%h exp=ffff", h_result); end
    h_run(rtype(5'd0, 5'd17, 5'd3, 5'd16, 6'h02), lat);
    checks++; if (h_result !== 16'h0000) begin failures++; $display("FAIL w16_srl16 got=%h exp=0", h_result); end
    h_run(rtype(5'd0, 5'd17, 5'd3, 5'd15, 6'h00), lat);
    checks++; if (h_result !== 16'h8000) begin failures++; $display("FAIL w16_sll15 got=%h exp=8000", h_result); end
    h_run(rtype(5'd16, 5'd17, 5'd3, 5'd0, 6'h07), lat);
    checks++; if (h_result !== 16'hF000) begin failures++; $display("FAIL w16_srav got=%h exp=f000", h_result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_slt_shift();
    test_back_to_back();
    test_illegal();
    test_debug();
    test_async_reset();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
